jk_excite_drv: RTL and testbench
================================

# jk_excite_drv

Excitation driver and checker for a JK flip-flop. It accepts a stream of target Q values and converts each transition into the required J/K drive using the excitation table. It drives an external `jk_ff`, compares the flip-flop's observed Q against the expected value, and counts mismatches. It is the inverse of the JK flip-flop: it maps desired state changes to J/K inputs, and it serves as the self-checking stimulus source for flip-flop blocks in the sequential-circuits set.

## Interface
- `DEPTH`, 4: target FIFO entries; power of two, ≥2.
- `ERR_W`, 8: mismatch counter width.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tgt_valid` in 1: target bit offered.
- `tgt_bit` in 1: desired next Q.
- `tgt_ready` out 1: FIFO can accept a bit.
- `step_en` in 1: permits one FIFO pop in this cycle.
- `j`, `k` out 1 each: registered drive to the flip-flop.
- `q_obs` in 1: Q from the driven flip-flop.
- `clr_err` in 1: clears `err_cnt` and `err_flag`.
- `err_cnt` out ERR_W: saturating mismatch count.
- `err_flag` out 1: sticky mismatch indicator.
- `busy` out 1: FIFO not empty or a check is pending.

## Operation
- FSM states:
  - INIT: entered on reset; lasts one cycle. Registers j=0, k=1 to force the flip-flop to Q=0 and sets the model q_m=0. Transitions to IDLE.
  - IDLE: FIFO empty. Drives j=0, k=0 (hold). Transitions to RUN when FIFO becomes non-empty.
  - RUN: pops one bit t per cycle while `step_en`=1 and FIFO is non-empty. Registers the J/K drive for q_m→t, then sets q_m←t. Transitions to IDLE when the FIFO empties. In a cycle with `step_en`=0, drives j=0, k=0 and schedules no check.
- Excitation, don't-cares resolved to 0 by default:
  - 0→0: J=0, K=0.
  - 0→1: J=1, K=0.
  - 1→0: J=0, K=1.
  - 1→1: J=0, K=0.
- Push: accepted when `tgt_valid` && `tgt_ready`. `tgt_ready` = !full && state≠INIT. It is computed from the registered count, with no same-cycle pop bypass.
- Check pipeline: two valid/expected stages. Each pop enters t into stage 1. At stage 2, `q_obs` is compared with the expected value; a mismatch increments `err_cnt`, which saturates at 2^ERR_W−1, and sets `err_flag`.
- q_m is not resynchronised on mismatch.
- `clr_err` coinciding with a mismatch: the clear applies first, so the result is `err_cnt`=1 and `err_flag`=1.

## Timing
- Reset values:
  - j=0, k=0.
  - `tgt_ready`=0.
  - `err_cnt`=0, `err_flag`=0.
  - `busy`=0.
  - FIFO empty, pipeline invalid, q_m=0, state INIT.
- `tgt_ready` rises one cycle after reset release.
- Pop in cycle N → j/k visible in N+1 → flip-flop samples at the end of N+1 → `q_obs` compared at the end of N+2.
- Push-to-first-pop latency: 1 cycle (the FIFO registers the push).
- `busy` falls in the cycle after the last check completes.
- Reset mid-operation: FIFO flushed, pending checks discarded, all outputs return to reset values asynchronously.

## Configuration
- `JK_TOGGLE_PREF_EN` defined: don't-cares resolve to 1, so every transition uses toggle, set or reset. The table becomes:
  - 0→0: J=0, K=1.
  - 0→1: J=1, K=1.
  - 1→0: J=1, K=1.
  - 1→1: J=1, K=0.
- `JK_TOGGLE_PREF_EN` undefined: the default table in Operation applies.
- INIT and idle drive are unaffected by the macro.

## Structure
- Package `jk_pkg` holds:
  - `jk_state_t` enum: INIT, IDLE, RUN.
  - `jk_drive_t` struct: {j, k}.
  - Function `jk_excite(q, t)`, containing the `JK_TOGGLE_PREF_EN` switch.
- Sub-module `jk_tgt_fifo`: 1-bit synchronous FIFO with DEPTH entries, full/empty outputs and count.
- Top level contains the FSM, drive registers, check pipeline and error counter.

## Test plan
- Reset, then `jk_ff` connected and `step_en`=1; push 1,0,0,1,1 → j/k sequence (1,0),(0,1),(0,0),(1,0),(0,0); `q_obs` follows 1,0,0,1,1; `err_cnt`=0; `busy` returns to 0.
- Same stimulus with `JK_TOGGLE_PREF_EN` defined → j/k sequence (1,1),(1,1),(0,1),(1,1),(1,0); `err_cnt`=0.
- `step_en`=0, push 6 bits with DEPTH=4 → 4 bits accepted, `tgt_ready`=0 thereafter; raise `step_en` → 4 pops, 4 checks pass.
- Invert `q_obs` for one compare cycle → `err_cnt`=1, `err_flag`=1, and the flag persists; pulse `clr_err` → both 0.
- ERR_W=2, `q_obs` tied to the complement of expected for 5 compares → `err_cnt` saturates at 3; `clr_err` on a mismatch cycle → `err_cnt`=1.
- Assert `rst_n` low with 3 bits queued → j=0, k=0, `busy`=0 immediately; after release, INIT drive j=0, k=1 for one cycle, then `tgt_ready`=1.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared types and the JK excitation table for jk_excite_drv.
// JK_TOGGLE_PREF_EN: resolve excitation don't-cares to 1 instead of 0.
package jk_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    RUN
  } jk_state_t;

  typedef struct packed {
    logic j;
    logic k;
  } jk_drive_t;

  localparam jk_drive_t JK_HOLD = '{j: 1'b0, k: 1'b0};
  localparam jk_drive_t JK_RST  = '{j: 1'b0, k: 1'b1};

  function automatic jk_drive_t jk_excite(
    input logic q,
    input logic t
  );
    jk_drive_t d;
`ifdef JK_TOGGLE_PREF_EN
    d.j = q | t;
    d.k = ~(q & t);
`else
    d.j = ~q & t;
    d.k = q & ~t;
`endif
    return d;
  endfunction

endpackage

// File: rtl/jk_tgt_fifo.sv
// 1-bit synchronous FIFO holding target Q values.
// DEPTH must be a power of two so pointers wrap naturally.
module jk_tgt_fifo
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          din_i,
  input  logic          pop_i,
  output logic          dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/jk_excite_drv.sv
// JK excitation driver/checker: FSM, drive regs, check pipe, error count.
// JK_TOGGLE_PREF_EN selects the toggle-preferring table in jk_pkg.
module jk_excite_drv
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  input  logic             step_en,
  output logic             j,
  output logic             k,
  input  logic             q_obs,
  input  logic             clr_err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_flag,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};

  jk_state_t        state_q;
  jk_drive_t        drv_q;
  logic             qm_q;
  logic             s1_v_q;
  logic             s1_e_q;
  logic             s2_v_q;
  logic             s2_e_q;
  logic [ERR_W-1:0] cnt_q;
  logic [ERR_W-1:0] cnt_d;
  logic             flag_q;
  logic             flag_d;

  logic             push;
  logic             pop;
  logic             more;
  logic             mism;
  logic             f_dout;
  logic             f_full;
  logic             f_empty;
  logic [CW-1:0]    f_cnt;

  assign tgt_ready = !f_full && (state_q != INIT);
  assign push      = tgt_valid && tgt_ready;
  assign pop       = (state_q != INIT) && step_en && !f_empty;
  assign more      = push || (f_cnt > CW'(pop));
  assign j         = drv_q.j;
  assign k         = drv_q.k;
  assign busy      = !f_empty || s1_v_q || s2_v_q;
  assign err_cnt   = cnt_q;
  assign err_flag  = flag_q;

  jk_tgt_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (tgt_bit),
    .pop_i   (pop),
    .dout_o  (f_dout),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_cnt)
  );

  // q_m tracks the intended flip-flop state, never the observed one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      drv_q   <= JK_HOLD;
      qm_q    <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          drv_q   <= JK_RST;
          qm_q    <= 1'b0;
          state_q <= IDLE;
        end
        IDLE, RUN: begin
          if (pop) begin
            drv_q <= jk_excite(qm_q, f_dout);
            qm_q  <= f_dout;
          end else begin
            drv_q <= JK_HOLD;
          end
          state_q <= more ? RUN : IDLE;
        end
        default: begin
          drv_q   <= JK_HOLD;
          state_q <= INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s1_e_q <= 1'b0;
      s2_v_q <= 1'b0;
      s2_e_q <= 1'b0;
    end else begin
      s1_v_q <= pop;
      s1_e_q <= pop ? f_dout : s1_e_q;
      s2_v_q <= s1_v_q;
      s2_e_q <= s1_e_q;
    end
  end

  assign mism = s2_v_q && (q_obs != s2_e_q);

  // clear takes effect before a coincident mismatch is counted
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clr_err) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end
    if (mism) begin
      flag_d = 1'b1;
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: tb/tb_jk_excite_drv.sv
// Scoreboard bench for jk_excite_drv with a behavioural JK flip-flop.
// Honours JK_TOGGLE_PREF_EN to pick the matching excitation table.
module tb_jk_excite_drv;

  localparam int DEPTH = 4;
  localparam int ERR_W = 8;
  localparam int CMAX  = (1 << ERR_W) - 1;

  typedef struct {
    logic             j;
    logic             k;
    logic             rdy;
    logic             busy;
    logic [ERR_W-1:0] cnt;
    logic             flag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tgt_valid = 1'b0;
  logic             tgt_bit = 1'b0;
  logic             tgt_ready;
  logic             step_en = 1'b0;
  logic             j;
  logic             k;
  logic             q_obs;
  logic             clr_err = 1'b0;
  logic [ERR_W-1:0] err_cnt;
  logic             err_flag;
  logic             busy;

  logic ff_q = 1'b1;
  logic inv = 1'b0;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  exp_t sb[$];
  bit   m_fifo[$];
  int   m_due[$];
  bit   m_init = 1'b1;
  bit   m_qm = 1'b0;
  int   m_cnt = 0;
  bit   m_flag = 1'b0;

  always #5 clk = ~clk;

  jk_excite_drv #(
    .DEPTH (DEPTH),
    .ERR_W (ERR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tgt_valid (tgt_valid),
    .tgt_bit   (tgt_bit),
    .tgt_ready (tgt_ready),
    .step_en   (step_en),
    .j         (j),
    .k         (k),
    .q_obs     (q_obs),
    .clr_err   (clr_err),
    .err_cnt   (err_cnt),
    .err_flag  (err_flag),
    .busy      (busy)
  );

  // external JK flip-flop under drive
  always @(posedge clk)
    ff_q <= (j & ~ff_q) | (~k & ff_q);

  assign q_obs = ff_q ^ inv;

  function automatic logic [1:0] ref_jk(bit q, bit t);
`ifdef JK_TOGGLE_PREF_EN
    case ({q, t})
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b10:   return 2'b11;
      default: return 2'b10;
    endcase
`else
    case ({q, t})
      2'b00:   return 2'b00;
      2'b01:   return 2'b10;
      2'b10:   return 2'b01;
      default: return 2'b00;
    endcase
`endif
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e.j = 0; e.k = 0; e.rdy = 0; e.busy = 0; e.cnt = '0; e.flag = 0;
    return e;
  endfunction

  function automatic void check(exp_t e, string tag);
    n_vec++;
    if (j !== e.j || k !== e.k || tgt_ready !== e.rdy ||
        busy !== e.busy || err_cnt !== e.cnt || err_flag !== e.flag) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got j%b k%b rdy%b busy%b cnt%0d flag%b want j%b k%b rdy%b busy%b cnt%0d flag%b",
               tag, cyc, j, k, tgt_ready, busy, err_cnt, err_flag,
               e.j, e.k, e.rdy, e.busy, e.cnt, e.flag);
    end
  endfunction

  // reference model: predicts outputs for the cycle after each edge
  always @(posedge clk) begin
    exp_t e;
    bit rdy;
    bit t;
    bit mism;
    logic [1:0] d;
    e = rst_exp();
    if (!rst_n) begin
      m_fifo.delete();
      m_due.delete();
      m_init = 1;
      m_qm = 0;
      m_cnt = 0;
      m_flag = 0;
    end else begin
      rdy = !m_init && (m_fifo.size() < DEPTH);
      mism = 0;
      if (m_init) begin
        e.j = 0; e.k = 1;
      end else if (step_en && m_fifo.size() > 0) begin
        t = m_fifo.pop_front();
        d = ref_jk(m_qm, t);
        e.j = d[1]; e.k = d[0];
        m_qm = t;
        m_due.push_back(cyc + 2);
      end
      if (tgt_valid && rdy) m_fifo.push_back(tgt_bit);
      if (m_due.size() > 0 && m_due[0] == cyc) begin
        void'(m_due.pop_front());
        mism = inv;
      end
      if (clr_err) begin
        m_cnt = 0; m_flag = 0;
      end
      if (mism) begin
        m_flag = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
      m_init = 0;
      e.rdy = m_fifo.size() < DEPTH;
      e.busy = (m_fifo.size() > 0) || (m_due.size() > 0);
      e.cnt = ERR_W'(m_cnt);
      e.flag = m_flag;
    end
    sb.push_back(e);
    cyc++;
  end

  // monitor: one comparison per cycle, away from the active edge
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() == 0) begin
      if (rst_n) begin
        n_vec++;
        n_miss++;
        $display("FAIL sb_underflow cyc=%0d got empty queue want entry", cyc);
      end
    end else begin
      e = sb.pop_front();
      if (!rst_n) e = rst_exp();
      check(e, "cycle");
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    check(rst_exp(), "async_reset");
    tick(2);
    rst_n = 1;
  endtask

  task automatic push_bits(bit b[], bit en);
    step_en = en;
    foreach (b[i]) begin
      tgt_valid = 1;
      tgt_bit = b[i];
      tick();
    end
    tgt_valid = 0;
  endtask

  initial begin
    bit seq5[] = '{1, 0, 0, 1, 1};
    bit seq6[] = '{1, 1, 0, 1, 0, 0};
    bit seq3[] = '{1, 0, 1};
    tick(3);
    rst_n = 1;
    tick(3);

    push_bits(seq5, 1);
    tick(8);

    push_bits(seq6, 0);
    tick(3);
    step_en = 1;
    tick(10);

    push_bits('{1}, 1);
    inv = 1;
    tick(6);
    inv = 0;
    tick(5);
    clr_err = 1;
    tick();
    clr_err = 0;
    tick(3);

    inv = 1;
    step_en = 1;
    for (int i = 0; i < 270; i++) begin
      tgt_valid = 1;
      tgt_bit = 1'($urandom);
      tick();
    end
    clr_err = 1;
    tick();
    clr_err = 0;
    tgt_valid = 0;
    tick(6);
    inv = 0;
    clr_err = 1;
    tick();
    clr_err = 0;

    for (int i = 0; i < 400; i++) begin
      tgt_valid = 1'($urandom);
      tgt_bit = 1'($urandom);
      step_en = ($urandom % 10) < 7;
      inv = ($urandom % 20) == 0;
      clr_err = ($urandom % 30) == 0;
      tick();
    end
    tgt_valid = 0;
    inv = 0;
    clr_err = 0;
    step_en = 1;
    tick(8);

    push_bits(seq3, 0);
    tick(2);
    do_reset();
    tick(4);
    push_bits(seq5, 1);
    tick(10);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
